// File: rtl/inst_cache_bridge.sv
// Direct-mapped, read-only instruction cache between a CPU fetch port and a
// slow req/ack instruction memory. Hits return combinationally; misses stall and refill.
module inst_cache_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [CNT_W-1:0]  hit_cnt_o,
  output logic [CNT_W-1:0]  miss_cnt_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t            state;
  state_t            state_next;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [ADDR_W-1:0] refill_addr;
  logic              flush_pending;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;

  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag;
  logic [IDX_W-1:0]  refill_index;
  logic [TAG_W-1:0]  refill_tag;
  logic              hit;
  logic              idle_hit;
  logic              launch;
  logic              ack;
  logic              unused_addr_bits;

  assign index        = addr_i[IDX_W+1:2];
  assign tag          = addr_i[ADDR_W-1:IDX_W+2];
  assign refill_index = refill_addr[IDX_W+1:2];
  assign refill_tag   = refill_addr[ADDR_W-1:IDX_W+2];
  assign unused_addr_bits = ^addr_i[1:0];

  // A flush in progress masks every line, so the lookup cannot hit that cycle
  assign hit      = ce_i & ~flush_i & valid[index] & (tag_mem[index] == tag);
  assign idle_hit = (state == IDLE) & hit;
  assign launch   = (state == IDLE) & ce_i & ~hit;
  assign ack      = (state == REFILL) & mem_ack_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = REFILL;
      REFILL:  if (mem_ack_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    inst_o    = '0;
    stall_o   = ce_i & ~idle_hit;
    mem_req_o = (state == REFILL);
    if (idle_hit) inst_o = data_mem[index];
  end

  assign mem_addr_o = refill_addr;
  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        refill_addr <= '0;
    else if (launch) refill_addr <= {addr_i[ADDR_W-1:2], 2'b00};
  end

  // A flush seen mid-refill poisons the line being fetched so it is never installed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid         <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (ack)
        flush_pending <= 1'b0;
      else if (flush_i && state == REFILL)
        flush_pending <= 1'b1;

      if (flush_i)
        valid <= '0;
      else if (ack && !flush_pending)
        valid[refill_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (ack) begin
      tag_mem[refill_index]  <= refill_tag;
      data_mem[refill_index] <= mem_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (idle_hit && hit_cnt != '1) hit_cnt  <= hit_cnt + CNT_W'(1);
      if (launch && miss_cnt != '1)  miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule
